// File: rtl/threat_section_scanner.sv
// Threat section scanner: latches a section of two-colour cells, then repeatedly
// picks the strongest unmarked 6-cell window per colour, counts it as a
// T4/T3/T2 threat, and marks its stones so that later picks cannot reuse them.
module threat_section_scanner #(
    parameter int SECTION_SIZE = 19,
    parameter int WIN_LEN      = 6,
    parameter int CNT_W        = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [2*SECTION_SIZE-1:0] section_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [CNT_W-1:0]          num_t4_b_o,
    output logic [CNT_W-1:0]          num_t3_b_o,
    output logic [CNT_W-1:0]          num_t2_b_o,
    output logic [CNT_W-1:0]          num_t4_w_o,
    output logic [CNT_W-1:0]          num_t3_w_o,
    output logic [CNT_W-1:0]          num_t2_w_o,
    output logic                      sat_b_o,
    output logic                      sat_w_o
);
    localparam int NUM_WIN = SECTION_SIZE - WIN_LEN + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // cls: 0 none, 1 T2, 2 T3, 3 T4; mask = own stones of the chosen window
    typedef struct packed {
        logic                    hit;
        logic [1:0]              cls;
        logic [SECTION_SIZE-1:0] mask;
    } pick_t;

    state_t                       state_q, state_d;
    logic [2*SECTION_SIZE-1:0]    snap_q, snap_d;
    logic [SECTION_SIZE-1:0]      mark_b_q, mark_b_d, mark_w_q, mark_w_d;
    // counter index 0 = T2, 1 = T3, 2 = T4
    logic [2:0][CNT_W-1:0]        cnt_b_q, cnt_b_d, cnt_w_q, cnt_w_d;
    logic                         sat_b_q, sat_b_d, sat_w_q, sat_w_d;
    logic [SECTION_SIZE-1:0]      blk, wht;
    pick_t                        pb, pw;

    // Highest class wins; scanning from the top with >= leaves the lowest index on ties.
    // A cell holding both bits is also set in opp, so it blocks the window too.
    function automatic pick_t pick(input logic [SECTION_SIZE-1:0] own,
                                   input logic [SECTION_SIZE-1:0] opp,
                                   input logic [SECTION_SIZE-1:0] mrk);
        pick_t                   p;
        logic [2:0]              n;
        logic                    bad;
        logic [1:0]              c;
        logic [SECTION_SIZE-1:0] m;
        p = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            n   = '0;
            bad = 1'b0;
            m   = '0;
            for (int k = 0; k < WIN_LEN; k++) begin
                if (opp[i+k] || mrk[i+k]) bad = 1'b1;
                if (own[i+k]) begin
                    n      = n + 3'd1;
                    m[i+k] = 1'b1;
                end
            end
            case (n)
                3'd4, 3'd5: c = 2'd3;
                3'd3:       c = 2'd2;
                3'd2:       c = 2'd1;
                default:    c = 2'd0;   // six own stones is not a threat
            endcase
            if (!bad && c != 2'd0 && c >= p.cls) begin
                p.hit  = 1'b1;
                p.cls  = c;
                p.mask = m;
            end
        end
        return p;
    endfunction

    // Split the snapshot into per-colour cell vectors (cell 0 at the MSBs).
    always_comb begin
        blk = '0;
        wht = '0;
        for (int k = 0; k < SECTION_SIZE; k++) begin
            blk[k] = snap_q[2*SECTION_SIZE-1-2*k];
            wht[k] = snap_q[2*SECTION_SIZE-2-2*k];
        end
    end

    assign pb = pick(blk, wht, mark_b_q);
    assign pw = pick(wht, blk, mark_w_q);

    // Next-state: start latching, per-colour threat accounting, termination.
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        mark_b_d = mark_b_q;
        mark_w_d = mark_w_q;
        cnt_b_d  = cnt_b_q;
        cnt_w_d  = cnt_w_q;
        sat_b_d  = sat_b_q;
        sat_w_d  = sat_w_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = SCAN;
                    snap_d   = section_i;
                    mark_b_d = '0;
                    mark_w_d = '0;
                    cnt_b_d  = '0;
                    cnt_w_d  = '0;
                    sat_b_d  = 1'b0;
                    sat_w_d  = 1'b0;
                end
            end
            SCAN: begin
                if (pb.hit) begin
                    mark_b_d = mark_b_q | pb.mask;
                    if (cnt_b_q[pb.cls-2'd1] == CNT_MAX) sat_b_d = 1'b1;
                    else cnt_b_d[pb.cls-2'd1] = cnt_b_q[pb.cls-2'd1] + 1'b1;
                end
                if (pw.hit) begin
                    mark_w_d = mark_w_q | pw.mask;
                    if (cnt_w_q[pw.cls-2'd1] == CNT_MAX) sat_w_d = 1'b1;
                    else cnt_w_d[pw.cls-2'd1] = cnt_w_q[pw.cls-2'd1] + 1'b1;
                end
                if (!pb.hit && !pw.hit) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any scan in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            snap_q   <= '0;
            mark_b_q <= '0;
            mark_w_q <= '0;
            cnt_b_q  <= '0;
            cnt_w_q  <= '0;
            sat_b_q  <= 1'b0;
            sat_w_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            mark_b_q <= mark_b_d;
            mark_w_q <= mark_w_d;
            cnt_b_q  <= cnt_b_d;
            cnt_w_q  <= cnt_w_d;
            sat_b_q  <= sat_b_d;
            sat_w_q  <= sat_w_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign num_t4_b_o = cnt_b_q[2];
    assign num_t3_b_o = cnt_b_q[1];
    assign num_t2_b_o = cnt_b_q[0];
    assign num_t4_w_o = cnt_w_q[2];
    assign num_t3_w_o = cnt_w_q[1];
    assign num_t2_w_o = cnt_w_q[0];
    assign sat_b_o    = sat_b_q;
    assign sat_w_o    = sat_w_q;
endmodule

// File: tb/tb_threat_section_scanner.sv
// Scoreboard bench: stimulus pushes hand-computed results, per-DUT monitors pop
// and compare on each done pulse. Latency counts edges with the start edge as #1.
module tb_threat_section_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 19 cells, DUT B: 25 cells, both CNT_W=2
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [37:0] sec_a = '0;
    logic [49:0] sec_b = '0;
    logic        busy_a, done_a, sbk_a, swt_a, busy_b, done_b, sbk_b, swt_b;
    logic [1:0]  a4b, a3b, a2b, a4w, a3w, a2w, b4b, b3b, b2b, b4w, b3w, b2w;

    threat_section_scanner #(.SECTION_SIZE(19), .WIN_LEN(6), .CNT_W(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .section_i(sec_a),
        .busy_o(busy_a), .done_o(done_a),
        .num_t4_b_o(a4b), .num_t3_b_o(a3b), .num_t2_b_o(a2b),
        .num_t4_w_o(a4w), .num_t3_w_o(a3w), .num_t2_w_o(a2w),
        .sat_b_o(sbk_a), .sat_w_o(swt_a));

    threat_section_scanner #(.SECTION_SIZE(25), .WIN_LEN(6), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .section_i(sec_b),
        .busy_o(busy_b), .done_o(done_b),
        .num_t4_b_o(b4b), .num_t3_b_o(b3b), .num_t2_b_o(b2b),
        .num_t4_w_o(b4w), .num_t3_w_o(b3w), .num_t2_w_o(b2w),
        .sat_b_o(sbk_b), .sat_w_o(swt_b));

    typedef struct {
        logic [11:0] cnt;   // {t4b,t3b,t2b,t4w,t3w,t2w}
        logic [1:0]  sat;   // {sat_b,sat_w}
        int          lat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int total = 0;
    int bad   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [24:0] cells(input int lo, input int hi);
        logic [24:0] r;
        r = '0;
        for (int k = lo; k <= hi; k++) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [37:0] enc19(input logic [24:0] b, input logic [24:0] w);
        logic [37:0] r;
        r = '0;
        for (int k = 0; k < 19; k++) begin
            r[37-2*k] = b[k];
            r[36-2*k] = w[k];
        end
        return r;
    endfunction

    function automatic logic [49:0] enc25(input logic [24:0] b, input logic [24:0] w);
        logic [49:0] r;
        r = '0;
        for (int k = 0; k < 25; k++) begin
            r[49-2*k] = b[k];
            r[48-2*k] = w[k];
        end
        return r;
    endfunction

    function automatic logic [11:0] pk(input int t4b, input int t3b, input int t2b,
                                       input int t4w, input int t3w, input int t2w);
        return {t4b[1:0], t3b[1:0], t2b[1:0], t4w[1:0], t3w[1:0], t2w[1:0]};
    endfunction

    function automatic exp_t mk(input logic [11:0] c, input logic [1:0] s, input int l);
        exp_t e;
        e.cnt = c;
        e.sat = s;
        e.lat = l;
        return e;
    endfunction

    // Monitor A
    int   ea = 0;
    logic pba = 1'b0, pda = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy_a && !pba) ea = 1;
        else if (busy_a) ea++;
        if (pda) cmp("a_done_one_cycle", {30'd0, busy_a, done_a}, 32'd0);
        if (done_a) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_done: got done with no pending scan");
            end else begin
                e = q_a.pop_front();
                cmp("a_counts", {20'd0, a4b, a3b, a2b, a4w, a3w, a2w}, {20'd0, e.cnt});
                cmp("a_sat", {30'd0, sbk_a, swt_a}, {30'd0, e.sat});
                cmp("a_latency", ea, e.lat);
            end
        end
        pba = busy_a;
        pda = done_a;
    end

    // Monitor B
    int   eb = 0;
    logic pbb = 1'b0, pdb = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy_b && !pbb) eb = 1;
        else if (busy_b) eb++;
        if (pdb) cmp("b_done_one_cycle", {30'd0, busy_b, done_b}, 32'd0);
        if (done_b) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_done: got done with no pending scan");
            end else begin
                e = q_b.pop_front();
                cmp("b_counts", {20'd0, b4b, b3b, b2b, b4w, b3w, b2w}, {20'd0, e.cnt});
                cmp("b_sat", {30'd0, sbk_b, swt_b}, {30'd0, e.sat});
                cmp("b_latency", eb, e.lat);
            end
        end
        pbb = busy_b;
        pdb = done_b;
    end

    task automatic wait_idle_a();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy_a) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL a_timeout: busy still %0b expected 0", busy_a);
        end
    endtask

    task automatic wait_idle_b();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy_b) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL b_timeout: busy still %0b expected 0", busy_b);
        end
    endtask

    // Called at a negedge with DUT idle.
    task automatic run_a(input logic [24:0] b, input logic [24:0] w, input exp_t e);
        q_a.push_back(e);
        sec_a   = enc19(b, w);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        sec_a   = '0;
        wait_idle_a();
        @(negedge clk);
    endtask

    task automatic run_b(input logic [24:0] b, input logic [24:0] w, input exp_t e);
        q_b.push_back(e);
        sec_b   = enc25(b, w);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        sec_b   = '0;
        wait_idle_b();
        @(negedge clk);
    endtask

    logic [24:0] pairs_b, pairs25;

    initial begin
        pairs_b = cells(0, 1) | cells(10, 11);
        pairs25 = cells(0, 1) | cells(6, 7) | cells(12, 13) | cells(18, 19);
        repeat (2) @(negedge clk);
        cmp("a_reset_state", {18'd0, busy_a, done_a, a4b, a3b, a2b, a4w, a3w, a2w, sbk_a, swt_a}, 32'd0);
        cmp("b_reset_state", {18'd0, busy_b, done_b, b4b, b3b, b2b, b4w, b3w, b2w, sbk_b, swt_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // four in a row -> one T4, done at 3rd edge
        run_a(cells(0, 3), '0, mk(pk(1,0,0,0,0,0), 2'b00, 3));
        // two separated pairs -> windows 0 and 6
        run_a(pairs_b, '0, mk(pk(0,0,2,0,0,0), 2'b00, 4));
        // white blocker kills every black window
        run_a(cells(0, 3), cells(4, 4), mk(pk(0,0,0,0,0,0), 2'b00, 2));
        // empty section
        run_a('0, '0, mk(pk(0,0,0,0,0,0), 2'b00, 2));
        // black five (window 10 T4 first), white three (window 2 T3)
        run_a(cells(12, 16), cells(5, 7), mk(pk(1,0,0,0,1,0), 2'b00, 3));
        // six in a row: window 0 not a threat, window 1 (five) is T4
        run_a(cells(0, 5), '0, mk(pk(1,0,0,0,0,0), 2'b00, 3));
        // cell 3 holds both bits -> no eligible window for either colour
        run_a(cells(0, 3), cells(3, 3), mk(pk(0,0,0,0,0,0), 2'b00, 2));
        // colours progress independently
        run_a(cells(0, 2), cells(13, 14), mk(pk(0,1,0,0,0,1), 2'b00, 3));

        // restart attempts during SCAN and DONE, section changed mid-scan
        q_a.push_back(mk(pk(0,0,2,0,0,0), 2'b00, 4));
        sec_a   = enc19(pairs_b, '0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        sec_a   = enc19('0, cells(0, 3));
        repeat (3) @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        cmp("a_no_restart", {31'd0, busy_a}, 32'd0);
        sec_a = '0;
        @(negedge clk);

        // reset mid-scan: immediate clear, no done, next scan clean
        sec_a   = enc19(pairs_b, '0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("a_abort_clear", {21'd0, busy_a, done_a, a4b, a3b, a2b, a4w, a3w, a2w, sbk_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_a(pairs_b, '0, mk(pk(0,0,2,0,0,0), 2'b00, 4));

        // 25-cell section: four T2 pairs saturate the 2-bit counter
        run_b(pairs25, '0, mk(pk(0,0,3,0,0,0), 2'b10, 6));
        run_b('0, pairs25, mk(pk(0,0,0,0,0,3), 2'b01, 6));
        run_b(cells(0, 3), '0, mk(pk(1,0,0,0,0,0), 2'b00, 3));

        repeat (2) @(negedge clk);
        cmp("a_pending", q_a.size(), 32'd0);
        cmp("b_pending", q_b.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/threat_section_scanner.md
THREAT_SECTION_SCANNER -- requirements
Module: threat_section_scanner

Interface
REQ-001 Parameter SECTION_SIZE, default 19, number of cells in the section (>=6).
REQ-002 Parameter WIN_LEN, fixed at 6, window length (cells); NUM_WIN = SECTION_SIZE-WIN_LEN+1.
REQ-003 Parameter CNT_W, default 2, width of each threat counter.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request to scan; sampled only in IDLE.
REQ-007 section  in  2*SECTION_SIZE  cell k = bits [2*SECTION_SIZE-1-2k] (black) and [2*SECTION_SIZE-2-2k] (white); cell 0 at MSBs.
REQ-008 busy  out  1  high while a scan is in progress.
REQ-009 done  out  1  one-cycle pulse when a scan completes.
REQ-010 num_t4_b, num_t3_b, num_t2_b, num_t4_w, num_t3_w, num_t2_w  out  CNT_W each  saturating threat counts.
REQ-011 sat_b, sat_w  out  1 each  sticky: any counter of that colour saturated in the current scan.

Function
REQ-012 States: IDLE, SCAN, DONE; IDLE->SCAN on start; SCAN->DONE when neither colour has a pending threat; DONE->IDLE unconditionally.
REQ-013 On accepted start: section latched into an internal snapshot; all marks, counters, and sat flags cleared at the same edge. Later changes to section are ignored until the next accepted start.
REQ-014 start while busy=1 or in DONE is ignored.
REQ-015 A window i (cells i..i+5) is eligible for colour C only if it contains no opponent stone, no cell with both bits set, and no cell marked for C.
REQ-016 Eligible window class by own-stone count: 4 or 5 -> T4; 3 -> T3; 2 -> T2; otherwise none. A count of 6 is not a threat.
REQ-017 Each SCAN cycle, per colour and independently, select the lowest-indexed window of the highest pending class (T4 > T3 > T2).
REQ-018 At the next edge: increment the matching counter and mark every own-stone cell of the selected window for that colour.
REQ-019 Counters saturate at 2^CNT_W-1; an increment at max holds the value and sets that colour's sat flag.
REQ-020 A colour with nothing pending idles; the other colour continues. Transition to DONE is taken only when both colours are idle in the same cycle.
REQ-021 busy=1 in SCAN and DONE; done=1 only in DONE. Counts are valid and stable from the DONE cycle until the next accepted start.
REQ-022 Latency: done rises at the (n+2)-th edge after the start edge, where n = max per-colour threat count found (empty section -> 2nd edge).
REQ-023 SCAN length is bounded by NUM_WIN cycles; no other termination is needed.
REQ-024 All outputs are registered or decoded from state only; no combinational path from start or section to any output.

Reset
REQ-025 rst=0 asynchronously forces IDLE, busy=0, done=0, all counters=0, sat flags=0, marks and snapshot cleared; this applies mid-scan, and the aborted scan is discarded.
REQ-026 After rst release, the first rising edge with start=1 starts a scan normally.

Verification (SECTION_SIZE=19, CNT_W=2 unless stated)
REQ-027 Stimulus: black cells 0-3, rest empty; start. Response: num_t4_b=1, all other counts 0; done pulses at the 3rd edge after start.
REQ-028 Stimulus: black cells 0,1 and 10,11. Response: num_t2_b=2 (window 0, then window 6); num_t4_b=num_t3_b=0; white counts 0.
REQ-029 Stimulus: black cells 0-3, white cell 4. Response: all six counts 0; done at the 2nd edge after start.
REQ-030 Stimulus: SECTION_SIZE=25, black pairs at cells 0-1, 6-7, 12-13, 18-19. Response: num_t2_b=3 (saturated), sat_b=1, sat_w=0.
REQ-031 Stimulus: start asserted again during SCAN, with section changed mid-scan. Response: no restart; counts reflect the originally latched section.
REQ-032 Stimulus: rst low for one cycle during SCAN. Response: immediately busy=0 and counts=0; no done pulse; the next start yields correct counts.
